// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode.
// Accepts 0/1/2 pushes and 0/1/2 pops per cycle; the two head entries are presented first-word fall-through.
module inst_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en1,
    input  logic                     wr_en2,
    input  logic [31:0]              wr_inst1,
    input  logic [31:0]              wr_pc1,
    input  logic [31:0]              wr_inst2,
    input  logic [31:0]              wr_pc2,
    input  logic                     rd_en1,
    input  logic                     rd_en2,
    output logic                     rd_valid1,
    output logic [31:0]              rd_inst1,
    output logic [31:0]              rd_pc1,
    output logic                     rd_valid2,
    output logic [31:0]              rd_inst2,
    output logic [31:0]              rd_pc2,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem_inst_q [DEPTH];
    logic [31:0]   mem_pc_q   [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] head_nxt;
    logic [AW-1:0] tail_nxt;
    logic [1:0]    n_push;
    logic [1:0]    n_pop;
    logic          full_int;
    logic          valid1_int;
    logic          valid2_int;

    assign head_nxt   = head_q + AW'(1);
    assign tail_nxt   = tail_q + AW'(1);
    assign valid1_int = (count_q != '0);
    assign valid2_int = (count_q >= CW'(2));
    // Full leaves headroom for a 2-push; judged on current occupancy only.
    assign full_int   = (count_q > CW'(DEPTH - 2));

    // Accepted push/pop counts after clamping.
    always_comb begin
        n_push = 2'd0;
        n_pop  = 2'd0;
        if (!full_int && wr_en1) begin
            n_push = wr_en2 ? 2'd2 : 2'd1;
        end
        if (rd_en1 && valid1_int) begin
            n_pop = (rd_en2 && valid2_int) ? 2'd2 : 2'd1;
        end
    end

    // Pointer and occupancy next state; flush discards everything.
    always_comb begin
        head_d  = head_q + AW'(n_pop);
        tail_d  = tail_q + AW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(n_pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale entries stay hidden behind rd_valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (n_push != 2'd0) begin
                mem_inst_q[tail_q] <= wr_inst1;
                mem_pc_q[tail_q]   <= wr_pc1;
            end
            if (n_push == 2'd2) begin
                mem_inst_q[tail_nxt] <= wr_inst2;
                mem_pc_q[tail_nxt]   <= wr_pc2;
            end
        end
    end

    always_comb begin
        rd_valid1 = valid1_int;
        rd_valid2 = valid2_int;
        rd_inst1  = valid1_int ? mem_inst_q[head_q]   : 32'd0;
        rd_pc1    = valid1_int ? mem_pc_q[head_q]     : 32'd0;
        rd_inst2  = valid2_int ? mem_inst_q[head_nxt] : 32'd0;
        rd_pc2    = valid2_int ? mem_pc_q[head_nxt]   : 32'd0;
        empty     = (count_q == '0);
        full      = full_int;
        count     = count_q;
    end

endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboard bench for inst_fifo: a queue-based reference model tracks expected contents,
// a negedge monitor compares every presented output against it.
module tb_inst_fifo;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        wr_en1, wr_en2, rd_en1, rd_en2;
    logic [31:0] wr_inst1, wr_pc1, wr_inst2, wr_pc2;
    logic        rd_valid1, rd_valid2, empty, full;
    logic [31:0] rd_inst1, rd_pc1, rd_inst2, rd_pc2;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    logic [31:0] next_pc;
    logic [63:0] exp_q [$];   // {inst, pc} in program order

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en1(wr_en1), .wr_en2(wr_en2),
        .wr_inst1(wr_inst1), .wr_pc1(wr_pc1), .wr_inst2(wr_inst2), .wr_pc2(wr_pc2),
        .rd_en1(rd_en1), .rd_en2(rd_en2),
        .rd_valid1(rd_valid1), .rd_inst1(rd_inst1), .rd_pc1(rd_pc1),
        .rd_valid2(rd_valid2), .rd_inst2(rd_inst2), .rd_pc2(rd_pc2),
        .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is simply the queue length.
    int sz;
    always @(posedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            sz = exp_q.size();
            if (rd_en1 && sz >= 1) void'(exp_q.pop_front());
            if (rd_en1 && rd_en2 && sz >= 2) void'(exp_q.pop_front());
            if (sz <= int'(DEPTH) - 2 && wr_en1) begin
                exp_q.push_back({wr_inst1, wr_pc1});
                if (wr_en2) exp_q.push_back({wr_inst2, wr_pc2});
            end
        end
    end

    // Monitor: compare presented outputs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("empty", 32'(empty), 32'(exp_q.size() == 0));
            chk("full", 32'(full), 32'(exp_q.size() > int'(DEPTH) - 2));
            chk("rd_valid1", 32'(rd_valid1), 32'(exp_q.size() >= 1));
            chk("rd_valid2", 32'(rd_valid2), 32'(exp_q.size() >= 2));
            chk("rd_pc1", rd_pc1, exp_q.size() >= 1 ? exp_q[0][31:0] : 32'd0);
            chk("rd_inst1", rd_inst1, exp_q.size() >= 1 ? exp_q[0][63:32] : 32'd0);
            chk("rd_pc2", rd_pc2, exp_q.size() >= 2 ? exp_q[1][31:0] : 32'd0);
            chk("rd_inst2", rd_inst2, exp_q.size() >= 2 ? exp_q[1][63:32] : 32'd0);
        end
    end

    // One clock of stimulus; PCs come from next_pc, inputs return to idle afterwards.
    task automatic cyc(input logic w1, input logic w2, input logic r1, input logic r2, input logic fl);
        wr_en1   = w1;
        wr_en2   = w2;
        wr_pc1   = next_pc;
        wr_pc2   = next_pc + 32'd4;
        wr_inst1 = $urandom;
        wr_inst2 = $urandom;
        rd_en1   = r1;
        rd_en2   = r2;
        flush    = fl;
        if (w1) next_pc = next_pc + (w2 ? 32'd8 : 32'd4);
        @(posedge clk);
        #1;
        wr_en1 = 1'b0; wr_en2 = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0; flush = 1'b0;
    endtask

    logic [31:0] pop_pc;
    logic [31:0] base;
    int          phase_w, phase_r;

    initial begin
        rst = 1'b1; flush = 1'b0;
        wr_en1 = 1'b0; wr_en2 = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;
        wr_inst1 = '0; wr_pc1 = '0; wr_inst2 = '0; wr_pc2 = '0;
        next_pc = 32'hbfc0_0000;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid1", 32'(rd_valid1), 32'd0);
        chk("rst_valid2", 32'(rd_valid2), 32'd0);
        chk("rst_pc1", rd_pc1, 32'd0);

        // Push pair
        cyc(1, 1, 0, 0, 0);
        @(negedge clk);
        chk("pair_count", 32'(count), 32'd2);
        chk("pair_pc1", rd_pc1, 32'hbfc0_0000);
        chk("pair_pc2", rd_pc2, 32'hbfc0_0004);

        // Fill to 15, then a push pair while full with one pop
        repeat (6) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("fill_count", 32'(count), 32'd15);
        chk("fill_full", 32'(full), 32'd1);
        cyc(1, 1, 1, 0, 0);
        @(negedge clk);
        chk("fullpush_count", 32'(count), 32'd14);
        chk("fullpush_pc1", rd_pc1, 32'hbfc0_0004);
        chk("fullpush_pc2", rd_pc2, 32'hbfc0_0008);

        // Steady push 2 / pop 2 across pointer wrap
        cyc(0, 0, 0, 0, 1);
        pop_pc = next_pc;
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stream_pc1", rd_pc1, pop_pc);
            chk("stream_pc2", rd_pc2, pop_pc + 32'd4);
            pop_pc = pop_pc + 32'd8;
            cyc(1, 1, 1, 1, 0);
        end
        @(negedge clk);
        chk("stream_count", 32'(count), 32'd2);

        // Flush at count 5 with simultaneous push
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("preflush_count", 32'(count), 32'd5);
        cyc(1, 1, 0, 0, 1);
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_valid1", 32'(rd_valid1), 32'd0);

        // Over-request clamp at count 1
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        @(negedge clk);
        chk("clamp_count", 32'(count), 32'd0);

        // rd_en2 alone and wr_en2 alone are ignored
        cyc(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("wr2only_count", 32'(count), 32'd0);

        // count 3, push 2 + pop 1
        base = next_pc;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("rd2only_count", 32'(count), 32'd3);
        cyc(1, 1, 1, 0, 0);
        @(negedge clk);
        chk("mix_count", 32'(count), 32'd4);
        chk("mix_pc1", rd_pc1, base + 32'd4);

        // Randomized traffic with phases biased toward filling or draining
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                phase_w = $urandom_range(1, 7);
                phase_r = $urandom_range(1, 7);
            end
            rst = ($urandom_range(0, 511) == 0);
            cyc($urandom_range(0, 7) < phase_w, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) < phase_r, $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) == 0);
            rst = 1'b0;
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
